uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serial UART transmit path. Counterpart of the UART receive path that loads instruction memory.
//   Accepts bytes over a valid/ready handshake into a small FIFO.
//   Serialises them 8N1, LSB first, onto the board TX pin.
//   Used for debug/status output from data_mem and for echoing loaded programs.
// PARAMETERS
//   CLK_FREQ    100_000_000  input clock frequency, Hz
//   BAUD        9600         line rate, bits/s
//   FIFO_DEPTH  4            byte FIFO entries; power of two, >= 2
//   CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD, integer-truncated; 10416 at the defaults
// PORTS
//   CLK           in   1  system clock; all state changes on rising edge
//   RST           in   1  synchronous reset, active-high
//   tx_data       in   8  byte to send
//   tx_valid      in   1  tx_data is valid this cycle
//   tx_ready      out  1  FIFO can accept a byte (= !full, combinational from registered count)
//   UART_RXD_OUT  out  1  serial line, idle high, registered
//   busy          out  1  frame in progress OR FIFO non-empty
//   fifo_count    out  clog2(FIFO_DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//   Reset (RST high at an edge): UART_RXD_OUT=1, tx_ready=1, busy=0, fifo_count=0.
//     FSM goes to IDLE, baud counter and bit index clear, FIFO flushed.
//     Reset mid-frame aborts the frame; the line is high after that edge.
//   Push: tx_valid && tx_ready at an edge writes tx_data. tx_valid while full is ignored; there is no bypass.
//   Simultaneous push and pop in the same edge: count unchanged, both take effect.
//   FSM states: IDLE -> START -> DATA -> STOP -> (START if FIFO non-empty, else IDLE).
//     Encoding lives in the shared header.
//   IDLE: FIFO non-empty at edge E -> pop into shift reg, state=START, line=0 from E.
//     A byte pushed into an empty FIFO at edge N therefore starts its frame at edge N+1.
//   Each bit holds for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
//   DATA sends bits 0..7; the bit index wraps 7 -> done.
//   STOP drives the line to 1 for one bit time.
//   At the end of STOP, if the FIFO is non-empty: pop and go to START on the same edge.
//     No idle gap is allowed between queued frames.
//   Frame = 10 bit times = 10*CLKS_PER_BIT cycles (11 with parity).
//   FIFO read/write pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     Adds state PARITY between DATA and STOP, sending even parity (^byte) for one bit time.
//   UART_TX_PARITY_EN undefined:
//     No PARITY state, no parity logic; frame is 8N1.
// STRUCTURE
//   Shared header uart_defs.vh: FSM state encodings, `UART_IDLE_LEVEL, frame bit counts.
//     Also included by the receive path.
//   Sub-module uart_tx_fifo: synchronous FIFO (push/pop/full/empty/count), reusable elsewhere.
//   Baud counter, shift register and FSM stay in this module.
// TESTING (bench: CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16)
//   1. Reset: hold RST 3 cycles -> UART_RXD_OUT=1, tx_ready=1, busy=0, fifo_count=0.
//   2. Push 0x55 at edge N -> line 0 from N+1, then bits 1,0,1,0,1,0,1,0 (LSB first) and stop 1.
//      Each bit lasts 16 cycles; busy falls at N+1+160.
//   3. Hold tx_valid with bytes 0x01..0x06 -> five accepted, tx_ready low until the first frame ends.
//      Six contiguous frames, no idle cycles between stop and next start.
//   4. Send 0xA5; assert RST during data bit 3 -> line 1 the next cycle.
//      No further frames; fifo_count=0.
//   5. With UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
//      Frame is 176 cycles.
//   6. Loopback UART_RXD_OUT into the existing receive path at default params.
//      Send 0x00, 0xFF, 0xA5 -> same bytes received in order.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: transmit FSM state encodings, line idle level,
// frame bit counts and the even-parity helper used by the parity build.
package uart_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam int   UART_DATA_BITS  = 8;
   localparam int   UART_FRAME_8N1  = 10;
   localparam int   UART_FRAME_8E1  = 11;

   // Even parity bit: makes the total count of ones in data+parity even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with push/pop, full/empty flags and occupancy count.
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: bytes enter a small FIFO over valid/ready and are
// serialised LSB first with start and stop bits (8N1). Queued frames are sent
// back to back with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1, 11 bit times per frame).
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          UART_RXD_OUT,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   tx_state_e       r_state;
   logic [CW-1:0]   r_baud_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            r_line;
`ifdef UART_TX_PARITY_EN
   logic            r_parity;
`endif

   logic [7:0]      w_fifo_data;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_bit_end;

   assign w_bit_end    = (r_baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_push       = tx_valid && !w_full;
   // Pop either to leave IDLE or to chain straight into the next frame at the end of STOP.
   assign w_pop        = !w_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
   assign tx_ready     = !w_full;
   assign busy         = (r_state != ST_IDLE) || !w_empty;
   assign UART_RXD_OUT = r_line;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_data  (tx_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   // Shift register: load the popped byte, shift right after each non-final data bit.
   always_ff @(posedge CLK) begin
      if (w_pop) begin
         r_shift <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
         r_parity <= even_parity(w_fifo_data);
`endif
      end else if ((r_state == ST_DATA) && w_bit_end && (r_bit_idx != 3'd7)) begin
         r_shift <= r_shift >> 1;
      end
   end

   // Frame FSM with baud counter, bit index and registered serial line.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_line     <= UART_IDLE_LEVEL;
      end else begin
         if (r_state == ST_IDLE) begin
            r_baud_cnt <= '0;
         end else if (w_bit_end) begin
            r_baud_cnt <= '0;
         end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
         end

         case (r_state)
            ST_IDLE: begin
               r_line <= UART_IDLE_LEVEL;
               if (w_pop) begin
                  r_state <= ST_START;
                  r_line  <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  r_line    <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_line  <= r_parity;
`else
                     r_state <= ST_STOP;
                     r_line  <= 1'b1;
`endif
                  end else begin
                     r_line <= r_shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_line  <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  if (!w_empty) begin
                     r_state <= ST_START;
                     r_line  <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_line  <= UART_IDLE_LEVEL;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_line  <= UART_IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed testbench for uart_transmitter at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_uart_transmitter;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        CLK;
   logic        RST;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        UART_RXD_OUT;
   logic        busy;
   logic [2:0]  fifo_count;

   int n_tests = 0;
   int n_fail  = 0;

   uart_transmitter #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .UART_RXD_OUT (UART_RXD_OUT),
      .busy         (busy),
      .fifo_count   (fifo_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #(100000 * 10);
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expects to be called #1 after the edge that starts the frame; returns #1 after its last edge.
   task automatic check_frame(input logic [7:0] b, input string tag);
      logic [10:0] bits;
      logic        obs;
      bits    = '1;
      bits[0] = 1'b0;
      bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      for (int k = 0; k < NBITS; k++) begin
         obs = bits[k];
         for (int c = 0; c < CPB; c++) begin
            if (UART_RXD_OUT !== bits[k]) obs = UART_RXD_OUT;
            @(posedge CLK); #1;
         end
         chk(32'(obs), 32'(bits[k]), $sformatf("%s bit%0d", tag, k));
      end
   endtask

   // Push one byte into an idle transmitter and check the whole frame.
   task automatic push_and_frame(input logic [7:0] b, input string tag);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge CLK); #1;
      tx_valid = 1'b0;
      chk(32'(UART_RXD_OUT), 32'd1, {tag, " line idle at push edge"});
      chk(32'(fifo_count), 32'd1, {tag, " count after push"});
      @(posedge CLK); #1;
      check_frame(b, tag);
      chk(32'(busy), 32'd0, {tag, " busy after frame"});
      chk(32'(UART_RXD_OUT), 32'd1, {tag, " line after frame"});
      chk(32'(fifo_count), 32'd0, {tag, " count after frame"});
   endtask

   initial begin
      logic ok;
      int   waited;
      logic acc;

      RST      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      chk(32'(UART_RXD_OUT), 32'd1, "reset line");
      chk(32'(tx_ready), 32'd1, "reset tx_ready");
      chk(32'(busy), 32'd0, "reset busy");
      chk(32'(fifo_count), 32'd0, "reset fifo_count");
      RST = 1'b0;
      @(posedge CLK); #1;

      // Single frames with varied data patterns
      push_and_frame(8'h55, "f55");
      push_and_frame(8'h00, "f00");
      push_and_frame(8'hFF, "fFF");
      push_and_frame(8'hA5, "fA5");

      // Held tx_valid with six bytes: FIFO fills, frames run back to back
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               tx_data  = 8'(i);
               tx_valid = 1'b1;
               waited   = 0;
               acc      = 1'b0;
               while (!acc && waited < 400) begin
                  acc = tx_ready;
                  @(posedge CLK); #1;
                  waited++;
               end
               chk(32'(acc), 32'd1, $sformatf("burst byte%0d accepted", i));
               if (i == 5) begin
                  chk(32'(tx_ready), 32'd0, "burst full tx_ready");
                  chk(32'(fifo_count), 32'd4, "burst full count");
               end
               if (i == 6) begin
                  chk(32'(waited), 32'd158, "burst byte6 wait cycles");
               end
            end
            tx_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge CLK);
            #1;
            for (int i = 1; i <= 6; i++) begin
               check_frame(8'(i), $sformatf("burst frame%0d", i));
            end
            chk(32'(busy), 32'd0, "burst busy at end");
            chk(32'(fifo_count), 32'd0, "burst count at end");
         end
      join

      // Reset in the middle of data bit 3 aborts the frame and flushes the queue
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(posedge CLK); #1;
      tx_data  = 8'h3C;
      @(posedge CLK); #1;
      tx_valid = 1'b0;
      repeat (64 + 8) @(posedge CLK);
      #1;
      chk(32'(UART_RXD_OUT), 32'd0, "abort mid bit3 level");
      chk(32'(fifo_count), 32'd1, "abort queued count");
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk(32'(UART_RXD_OUT), 32'd1, "abort line after reset");
      chk(32'(fifo_count), 32'd0, "abort fifo_count");
      chk(32'(busy), 32'd0, "abort busy");
      chk(32'(tx_ready), 32'd1, "abort tx_ready");
      ok = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (UART_RXD_OUT !== 1'b1 || busy !== 1'b0) ok = 1'b0;
         @(posedge CLK); #1;
      end
      chk(32'(ok), 32'd1, "abort no further frames");

`ifdef UART_TX_PARITY_EN
      push_and_frame(8'h07, "par07");
      push_and_frame(8'h03, "par03");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
